// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and data access.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data access always wins a tie.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              tmo_err_o
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                memReq_q, memReq_d;
    logic                memWe_q, memWe_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memWdata_q, memWdata_d;
    logic                ifAck_q, ifAck_d;
    logic                dmAck_q, dmAck_d;
    logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0]   dmRdata_q, dmRdata_d;
    logic [CNT_W-1:0]    tmoCnt_q, tmoCnt_d;
    logic                tmoErr_q, tmoErr_d;
`ifdef ARB_RR_EN
    logic                lastDm_q, lastDm_d;
`endif

    logic ifElig;
    logic dmElig;
    logic grantDm;
    logic tmoHit;

    // A port whose ack is being pulsed this cycle still shows its old request, so mask it.
    assign ifElig = if_req_i & ~ifAck_q;
    assign dmElig = dm_req_i & ~dmAck_q;
`ifdef ARB_RR_EN
    assign grantDm = dmElig & (~ifElig | ~lastDm_q);
`else
    assign grantDm = dmElig;
`endif
    assign tmoHit = (tmoCnt_q == CNT_W'(TMO_CYC - 1));

    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        ifAck_d    = 1'b0;
        dmAck_d    = 1'b0;
        ifRdata_d  = ifRdata_q;
        dmRdata_d  = dmRdata_q;
        tmoCnt_d   = tmoCnt_q;
        tmoErr_d   = tmoErr_q;
`ifdef ARB_RR_EN
        lastDm_d   = lastDm_q;
`endif
        case (state_q)
            IDLE: begin
                if (grantDm) begin
                    state_d    = GNT_DM;
                    memReq_d   = 1'b1;
                    memWe_d    = dm_we_i;
                    memAddr_d  = dm_addr_i;
                    memWdata_d = dm_wdata_i;
                    tmoCnt_d   = '0;
`ifdef ARB_RR_EN
                    lastDm_d   = 1'b1;
`endif
                end else if (ifElig) begin
                    state_d    = GNT_IF;
                    memReq_d   = 1'b1;
                    memWe_d    = 1'b0;
                    memAddr_d  = if_addr_i;
                    memWdata_d = '0;
                    tmoCnt_d   = '0;
`ifdef ARB_RR_EN
                    lastDm_d   = 1'b0;
`endif
                end
            end
            GNT_IF, GNT_DM: begin
                // A real ack wins over a timeout landing in the same cycle.
                if (mem_ack_i || tmoHit) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                    if (!mem_ack_i) begin
                        tmoErr_d = 1'b1;
                    end
                    if (state_q == GNT_DM) begin
                        dmAck_d   = 1'b1;
                        dmRdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end else begin
                        ifAck_d   = 1'b1;
                        ifRdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            ifAck_q    <= 1'b0;
            dmAck_q    <= 1'b0;
            ifRdata_q  <= '0;
            dmRdata_q  <= '0;
            tmoCnt_q   <= '0;
            tmoErr_q   <= 1'b0;
`ifdef ARB_RR_EN
            lastDm_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            ifAck_q    <= ifAck_d;
            dmAck_q    <= dmAck_d;
            ifRdata_q  <= ifRdata_d;
            dmRdata_q  <= dmRdata_d;
            tmoCnt_q   <= tmoCnt_d;
            tmoErr_q   <= tmoErr_d;
`ifdef ARB_RR_EN
            lastDm_q   <= lastDm_d;
`endif
        end
    end

    assign if_rdata_o  = ifRdata_q;
    assign if_ack_o    = ifAck_q;
    assign if_stall_o  = if_req_i & ~ifAck_q;
    assign dm_rdata_o  = dmRdata_q;
    assign dm_ack_o    = dmAck_q;
    assign dm_stall_o  = dm_req_i & ~dmAck_q;
    assign mem_req_o   = memReq_q;
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign tmo_err_o   = tmoErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int TMO = 64;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        tmo_err;

    int tests = 0;
    int fails = 0;

    // Model of what the arbiter's visible outputs must be after each edge.
    bit          mBusy, mPortDm, mWe, mIfAck, mDmAck, mErr, mLastDm;
    logic [31:0] mAddr, mWdata, mIfRdata, mDmRdata;
    int          mWait;
    int          curLat;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_ack_o(if_ack), .if_stall_o(if_stall),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .dm_stall_o(dm_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .tmo_err_o(tmo_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Finish the transaction in flight: ack pulse and read data for the owning port.
    task automatic modelComplete(input logic [31:0] data);
        mBusy = 1'b0;
        if (mPortDm) begin
            mDmAck = 1'b1;
            mDmRdata = data;
        end else begin
            mIfAck = 1'b1;
            mIfRdata = data;
        end
    endtask

    task automatic modelStep();
        bit ifE, dmE, takeDm;
        if (rst) begin
            mBusy = 0; mPortDm = 0; mWe = 0; mIfAck = 0; mDmAck = 0; mErr = 0; mLastDm = 0;
            mAddr = 0; mWdata = 0; mIfRdata = 0; mDmRdata = 0; mWait = 0;
            return;
        end
        ifE = if_req && !mIfAck;
        dmE = dm_req && !mDmAck;
        mIfAck = 1'b0;
        mDmAck = 1'b0;
        if (!mBusy) begin
            takeDm = dmE && (!ifE || !RR || !mLastDm);
            if (takeDm || ifE) begin
                mBusy = 1'b1;
                mPortDm = takeDm;
                mLastDm = takeDm;
                mAddr = takeDm ? dm_addr : if_addr;
                mWe = takeDm ? dm_we : 1'b0;
                mWdata = takeDm ? dm_wdata : 32'h0;
                mWait = 0;
                curLat = ($urandom_range(0, 49) == 0) ? 200 : $urandom_range(0, 3);
            end
        end else if (mem_ack) begin
            modelComplete(mem_rdata);
        end else begin
            mWait++;
            if (mWait == TMO) begin
                mErr = 1'b1;
                modelComplete(32'h0);
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("mem_req", {31'd0, mem_req}, {31'd0, mBusy});
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, mWe});
        checkOutput("mem_addr", mem_addr, mAddr);
        checkOutput("mem_wdata", mem_wdata, mWdata);
        checkOutput("if_ack", {31'd0, if_ack}, {31'd0, mIfAck});
        checkOutput("dm_ack", {31'd0, dm_ack}, {31'd0, mDmAck});
        checkOutput("if_rdata", if_rdata, mIfRdata);
        checkOutput("dm_rdata", dm_rdata, mDmRdata);
        checkOutput("tmo_err", {31'd0, tmo_err}, {31'd0, mErr});
        checkOutput("if_stall", {31'd0, if_stall}, {31'd0, if_req && !mIfAck});
        checkOutput("dm_stall", {31'd0, dm_stall}, {31'd0, dm_req && !mDmAck});
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    bit ifActive, dmActive;

    // Random requesters hold a request until acked; the memory acks after curLat cycles.
    task automatic applyStimulus();
        if (ifActive && mIfAck) ifActive = 1'b0;
        if (dmActive && mDmAck) dmActive = 1'b0;
        if (!ifActive && $urandom_range(0, 3) == 0) begin
            ifActive = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!dmActive && $urandom_range(0, 3) == 0) begin
            dmActive = 1'b1;
            dm_addr = $urandom;
            dm_we = 1'($urandom_range(0, 1));
            dm_wdata = $urandom;
        end
        if_req = ifActive;
        dm_req = dmActive;
        mem_rdata = $urandom;
        if (mBusy) mem_ack = (mWait >= curLat);
        else mem_ack = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 299) == 0);
    endtask

    task automatic idleInputs();
        rst = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
    endtask

    logic [31:0] grants[$];
    int          n;

    initial begin
        idleInputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_tmo_err", {31'd0, tmo_err}, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);

        // Fetch alone, latency 2.
        if_req = 1; if_addr = 32'h10;
        tick();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) n++;
            checkOutput("t1_stall", {31'd0, if_stall}, 32'd1);
            mem_ack = (i == 2);
            mem_rdata = (i == 2) ? 32'h00A00093 : 32'h0;
            tick();
        end
        mem_ack = 0;
        checkOutput("t1_req_cycles", n, 32'd3);
        checkOutput("t1_ack", {31'd0, if_ack}, 32'd1);
        checkOutput("t1_rdata", if_rdata, 32'h00A00093);
        if_req = 0;
        tick();

        // Simultaneous requests, latency 0: data first, then fetch.
        if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
        tick();
        checkOutput("t2_addr_dm", mem_addr, 32'h20);
        mem_ack = 1; mem_rdata = 32'h55;
        tick();
        checkOutput("t2_dm_ack", {31'd0, dm_ack}, 32'd1);
        checkOutput("t2_dm_rdata", dm_rdata, 32'h55);
        dm_req = 0; mem_ack = 0;
        tick();
        checkOutput("t2_addr_if", mem_addr, 32'h14);
        mem_ack = 1; mem_rdata = 32'h11;
        tick();
        checkOutput("t2_if_ack", {31'd0, if_ack}, 32'd1);
        checkOutput("t2_if_rdata", if_rdata, 32'h11);
        if_req = 0; mem_ack = 0;
        tick();

        // Store; stale request in the ack cycle must not be re-granted.
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hCAFEF00D;
        tick();
        tick();
        checkOutput("t3_we", {31'd0, mem_we}, 32'd1);
        checkOutput("t3_addr", mem_addr, 32'h40);
        checkOutput("t3_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1;
        tick();
        checkOutput("t3_ack", {31'd0, dm_ack}, 32'd1);
        mem_ack = 0;
        tick();
        checkOutput("t3_no_regrant", {31'd0, mem_req}, 32'd0);
        dm_req = 0; dm_we = 0;
        tick();

        // Memory never answers.
        if_req = 1; if_addr = 32'h80;
        tick();
        n = 0;
        for (int i = 0; i < 100 && !if_ack; i++) begin
            if (mem_req) n++;
            tick();
        end
        checkOutput("t4_gnt_cycles", n, TMO);
        checkOutput("t4_ack", {31'd0, if_ack}, 32'd1);
        checkOutput("t4_rdata", if_rdata, 32'd0);
        checkOutput("t4_err", {31'd0, tmo_err}, 32'd1);
        if_req = 0;
        tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h44;
        tick();
        tick();
        mem_ack = 1; mem_rdata = 32'h1234;
        tick();
        checkOutput("t4_after_ack", {31'd0, dm_ack}, 32'd1);
        checkOutput("t4_after_data", dm_rdata, 32'h1234);
        checkOutput("t4_err_sticky", {31'd0, tmo_err}, 32'd1);
        dm_req = 0; mem_ack = 0;
        tick();

        // Reset in the middle of a data grant; late ack must be ignored.
        dm_req = 1; dm_addr = 32'h60;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        checkOutput("t5_req", {31'd0, mem_req}, 32'd0);
        checkOutput("t5_err", {31'd0, tmo_err}, 32'd0);
        checkOutput("t5_addr", mem_addr, 32'd0);
        dm_req = 0; mem_ack = 1;
        tick();
        checkOutput("t5_no_ack", {31'd0, dm_ack}, 32'd0);
        mem_ack = 0;

        // Both ports requesting continuously, latency 0.
        if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            mem_ack = mBusy;
            tick();
            if (mem_req) grants.push_back(mem_addr);
        end
        if_req = 0; dm_req = 0; mem_ack = 0;
        tick();
        checkOutput("t6_count", grants.size(), 32'd4);
        if (grants.size() == 4) begin
            checkOutput("t6_g0", grants[0], 32'h200);
            checkOutput("t6_g1", grants[1], 32'h100);
            checkOutput("t6_g2", grants[2], 32'h200);
            checkOutput("t6_g3", grants[3], 32'h100);
        end

        // Tie right after a lone data grant: round-robin hands it to fetch.
        dm_req = 1; dm_addr = 32'h300;
        tick();
        mem_ack = 1;
        tick();
        dm_req = 0; mem_ack = 0;
        tick();
        if_req = 1; if_addr = 32'h104; dm_req = 1; dm_addr = 32'h304;
        tick();
        checkOutput("t7_tie", mem_addr, RR ? 32'h104 : 32'h304);
        mem_ack = 1;
        tick();
        if_req = 0; dm_req = 0; mem_ack = 0;
        tick();

        ifActive = 0; dmActive = 0;
        for (int i = 0; i < 5000; i++) begin
            applyStimulus();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
